// File: rtl/align_shifter_pipe.sv
// -----------------------------------------------------------------------------
// align_shifter_pipe
//
// Pipelined alignment right-shifter for the L1 operand preparer. The IN_W-bit
// mantissa is MSB-aligned into an OUT_W-bit field and shifted right by
// in_shift. Vacated high bits take the fill bit (in_sig, suppressed for a zero
// mantissa). The shift amount is split into STAGES contiguous bit groups,
// LSB group first. Each register stage applies one group, so no single
// combinational barrel spans the whole exponent-difference range.
//
// Every stage holds a valid flag and loads whenever it is empty or its
// contents move on in the same cycle, so bubbles collapse under backpressure
// and full throughput is kept while out_ready = 1.
//
// Configuration macro:
//   ALIGN_SHIFT_STICKY_EN  defined     -> sticky logic built, out_sticky live
//                          not defined -> no sticky logic, out_sticky = 0
//
// Ports:
//   clk, rst_n   clock; asynchronous active-low reset
//   flush        synchronous drop of every in-flight transaction
//   in_valid / in_ready / in_data / in_shift / in_sig / in_tag
//                input handshake, mantissa, shift amount, fill bit, tag
//   out_valid / out_ready / out_data / out_sticky / out_tag
//                output handshake, aligned result, sticky bit, tag
// -----------------------------------------------------------------------------
module align_shifter_pipe #(
  parameter int IN_W   = 26,
  parameter int OUT_W  = 50,
  parameter int SH_W   = 5,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [SH_W-1:0]  in_shift,
  input  logic             in_sig,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sticky,
  output logic [TAG_W-1:0] out_tag
);

  // Lowest shift bit handled by stage s. The first (SH_W % STAGES) groups
  // are one bit wider, so the partition covers all SH_W bits for any legal
  // STAGES. grp_lo(STAGES) == SH_W.
  function automatic int grp_lo(input int s);
    int base;
    int extra;
    base  = SH_W / STAGES;
    extra = SH_W % STAGES;
    return s * base + ((s < extra) ? s : extra);
  endfunction

  localparam logic [OUT_W-1:0] ONES = '1;

  // Stage registers
  logic [STAGES-1:0] r_valid;
  logic [OUT_W-1:0]  r_data  [STAGES];
  logic              r_fill  [STAGES];
  logic [SH_W-1:0]   r_shift [STAGES];
  logic [TAG_W-1:0]  r_tag   [STAGES];

  // Next-value of each stage's datapath, computed from the previous stage
  logic [OUT_W-1:0]  w_nxt_data  [STAGES];
  logic              w_nxt_fill  [STAGES];
  logic [SH_W-1:0]   w_nxt_shift [STAGES];
  logic [TAG_W-1:0]  w_nxt_tag   [STAGES];

`ifdef ALIGN_SHIFT_STICKY_EN
  logic              r_sticky     [STAGES];
  logic              w_nxt_sticky [STAGES];
`endif

  // Handshake: w_ready[s] means stage s may load this cycle;
  // w_ready[STAGES] is the downstream consumer.
  logic [STAGES:0]   w_ready;
  logic [STAGES-1:0] w_load;
  logic              w_in_ready;

  // ---------------------------------------------------------------------------
  // Per-stage shift datapath
  // ---------------------------------------------------------------------------
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = grp_lo(s);
    localparam int HI = grp_lo(s + 1);
    // Shift bits [HI-1:LO] belong to this stage; masking keeps them at their
    // binary weight so the stage shifts by exactly that group's contribution.
    localparam logic [SH_W-1:0] GMASK =
      SH_W'(((64'd1 << HI) - 64'd1) & ~((64'd1 << LO) - 64'd1));

    logic [OUT_W-1:0] w_d_in;
    logic             w_f_in;
    logic [SH_W-1:0]  w_sh_in;
    logic [TAG_W-1:0] w_tag_in;
    logic [SH_W-1:0]  w_amt;

    if (s == 0) begin : g_first
      assign w_d_in   = OUT_W'(in_data) << (OUT_W - IN_W);
      // A zero mantissa must give an all-zero result, so the fill is gated.
      assign w_f_in   = in_sig & (|in_data);
      assign w_sh_in  = in_shift;
      assign w_tag_in = in_tag;
    end else begin : g_next
      assign w_d_in   = r_data[s-1];
      assign w_f_in   = r_fill[s-1];
      assign w_sh_in  = r_shift[s-1];
      assign w_tag_in = r_tag[s-1];
    end

    assign w_amt = w_sh_in & GMASK;

    // Right shift with fill: an amount of OUT_W or more leaves only fill bits,
    // because both shifted terms become zero and the fill mask becomes full.
    assign w_nxt_data[s]  = (w_d_in >> w_amt) | ({OUT_W{w_f_in}} & ~(ONES >> w_amt));
    assign w_nxt_fill[s]  = w_f_in;
    assign w_nxt_shift[s] = w_sh_in;
    assign w_nxt_tag[s]   = w_tag_in;

`ifdef ALIGN_SHIFT_STICKY_EN
    // Partial sticky: OR of the bits this stage pushes below bit 0. Fill bits
    // can only be lost once the total shift exceeds OUT_W, which implies a
    // non-zero mantissa, so the accumulated value still equals the OR of the
    // original extended operand's low bits.
    logic w_st_in;
    if (s == 0) begin : g_st_first
      assign w_st_in = 1'b0;
    end else begin : g_st_next
      assign w_st_in = r_sticky[s-1];
    end
    assign w_nxt_sticky[s] = w_st_in | (|(w_d_in & ~(ONES << w_amt)));
`endif
  end

  // ---------------------------------------------------------------------------
  // Elastic handshake: a stage can load when it is empty or when its own
  // contents are moving on, which reduces to an OR chain back from out_ready.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    w_ready = '0;
    w_load  = '0;
    w_ready[STAGES] = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      w_ready[s] = !r_valid[s] || w_ready[s+1];
    end
    w_in_ready = w_ready[0] && !flush;
    w_load[0]  = in_valid && w_in_ready;
    for (int s = 1; s < STAGES; s++) begin
      w_load[s] = r_valid[s-1] && w_ready[s];
    end
  end

  assign in_ready = w_in_ready & rst_n;

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      // NOTE: the datapath registers are reset too, because the last stage
      // drives out_data/out_tag directly and those must read 0 out of reset.
      for (int s = 0; s < STAGES; s++) begin
        r_data[s]  <= '0;
        r_fill[s]  <= 1'b0;
        r_shift[s] <= '0;
        r_tag[s]   <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        // NOTE: non-blocking assignments so every stage samples the values
        // its predecessor held before this edge.
        if (flush) begin
          r_valid[s] <= 1'b0;
        end else if (w_ready[s]) begin
          r_valid[s] <= w_load[s];
        end
        if (w_load[s]) begin
          r_data[s]  <= w_nxt_data[s];
          r_fill[s]  <= w_nxt_fill[s];
          r_shift[s] <= w_nxt_shift[s];
          r_tag[s]   <= w_nxt_tag[s];
        end
      end
    end
  end

`ifdef ALIGN_SHIFT_STICKY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        r_sticky[s] <= 1'b0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (w_load[s]) begin
          r_sticky[s] <= w_nxt_sticky[s];
        end
      end
    end
  end

  assign out_sticky = r_sticky[STAGES-1];
`else
  assign out_sticky = 1'b0;
`endif

  assign out_valid = r_valid[STAGES-1];
  assign out_data  = r_data[STAGES-1];
  assign out_tag   = r_tag[STAGES-1];

endmodule

// File: tb/tb_align_shifter_pipe.sv
// -----------------------------------------------------------------------------
// tb_align_shifter_pipe
//
// Self-checking bench for align_shifter_pipe with default parameters. The
// reference model computes each result bit directly from the alignment
// formula; a queue of expected results tracks transactions in flight.
// Honours ALIGN_SHIFT_STICKY_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_align_shifter_pipe;

  localparam int IN_W   = 26;
  localparam int OUT_W  = 50;
  localparam int SH_W   = 5;
  localparam int STAGES = 3;
  localparam int TAG_W  = 4;

`ifdef ALIGN_SHIFT_STICKY_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             flush     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data   = '0;
  logic [SH_W-1:0]  in_shift  = '0;
  logic             in_sig    = 1'b0;
  logic [TAG_W-1:0] in_tag    = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic             out_sticky;
  logic [TAG_W-1:0] out_tag;

  always #5 clk = ~clk;

  align_shifter_pipe #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .SH_W   (SH_W),
    .STAGES (STAGES),
    .TAG_W  (TAG_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_shift   (in_shift),
    .in_sig     (in_sig),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sticky (out_sticky),
    .out_tag    (out_tag)
  );

  typedef struct packed {
    logic [OUT_W-1:0] d;
    logic             st;
    logic [TAG_W-1:0] tag;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [OUT_W-1:0] d, input logic st, input logic [TAG_W-1:0] tag);
    exp_t e;
    e.d   = d;
    e.st  = st & STICKY_ON;
    e.tag = tag;
    return e;
  endfunction

  // Bit-by-bit evaluation of the alignment rules.
  function automatic exp_t model(input logic [IN_W-1:0] d, input logic [SH_W-1:0] shv,
                                 input logic sig, input logic [TAG_W-1:0] tag);
    exp_t             e;
    logic [OUT_W-1:0] ex;
    logic             fill;
    int               sh;
    sh   = int'(shv);
    ex   = '0;
    ex[OUT_W-1 -: IN_W] = d;
    fill = sig && (d != '0);
    for (int i = 0; i < OUT_W; i++) begin
      e.d[i] = (i > OUT_W - 1 - sh) ? fill : ex[i + sh];
    end
    e.st = 1'b0;
    for (int i = 0; i < OUT_W && i < sh; i++) begin
      e.st = e.st | ex[i];
    end
    e.st  = e.st & STICKY_ON;
    e.tag = tag;
    return e;
  endfunction

  task automatic drive_random(input logic [TAG_W-1:0] tag);
    case ($urandom_range(0, 3))
      0:       in_data = '0;
      1:       in_data = IN_W'($urandom_range(1, 15));
      default: in_data = IN_W'($urandom);
    endcase
    in_shift = SH_W'($urandom_range(0, (1 << SH_W) - 1));
    in_sig   = 1'($urandom_range(0, 1));
    in_tag   = tag;
  endtask

  // One scoreboard cycle, entered just after a falling edge with inputs set.
  task automatic tick(output bit accepted);
    exp_t             e;
    bit               hold;
    logic [63:0]      held;
    #1;
    check("in_ready_rule", 64'(in_ready), 64'((sb.size() < STAGES) || out_ready));
    if (sb.size() == STAGES) check("full_out_valid", 64'(out_valid), 64'(1));
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        check("data", 64'(out_data), 64'(e.d));
        check("sticky", 64'(out_sticky), 64'(e.st));
        check("tag", 64'(out_tag), 64'(e.tag));
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) sb.push_back(model(in_data, in_shift, in_sig, in_tag));
    hold = out_valid && !out_ready;
    held = 64'({out_valid, out_data, out_sticky, out_tag});
    @(posedge clk);
    #1;
    if (hold) check("hold_stable", 64'({out_valid, out_data, out_sticky, out_tag}), held);
    @(negedge clk);
  endtask

  // Single transaction into an empty pipe, checking exact latency.
  task automatic directed(input string name, input logic [IN_W-1:0] d, input logic [SH_W-1:0] sh,
                          input logic sig, input logic [TAG_W-1:0] tag, input exp_t e);
    in_data = d; in_shift = sh; in_sig = sig; in_tag = tag;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 check({name, "_in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 1; k < STAGES; k++) begin
      check({name, "_early_valid"}, 64'(out_valid), 64'(0));
      @(posedge clk);
      #1;
    end
    check({name, "_valid"}, 64'(out_valid), 64'(1));
    check({name, "_data"}, 64'(out_data), 64'(e.d));
    check({name, "_sticky"}, 64'(out_sticky), 64'(e.st));
    check({name, "_tag"}, 64'(out_tag), 64'(e.tag));
    @(posedge clk);
    #1 check({name, "_consumed"}, 64'(out_valid), 64'(0));
    @(negedge clk);
  endtask

  // Load three transactions with out_ready low, leaving the pipe full.
  task automatic prefill3();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_random(TAG_W'(i));
      in_valid = 1'b1;
      #1 check("prefill_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
    end
    check("prefill_out_valid", 64'(out_valid), 64'(1));
  endtask

  initial begin
    bit acc;
    int sent;
    logic [TAG_W-1:0] tag_ctr;

    // ---- reset state ----
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_sticky", 64'(out_sticky), 64'(0));
    check("rst_out_tag", 64'(out_tag), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);

    // ---- directed vectors ----
    directed("t1", 26'h2000001, 5'd0, 1'b1, 4'h1, mk(50'h2000001000000, 1'b0, 4'h1));
    directed("t2", 26'h3FFFFFF, 5'd4, 1'b1, 4'h2, mk(50'h3FFFFFFF00000, 1'b0, 4'h2));
    directed("t3", 26'h0000000, 5'd31, 1'b1, 4'h3, mk(50'h0, 1'b0, 4'h3));
    directed("t4", 26'h0000001, 5'd31, 1'b0, 4'h4, mk(50'h0, 1'b1, 4'h4));
    directed("t5", 26'h2AAAAAA, 5'd25, 1'b1, 4'h5, model(26'h2AAAAAA, 5'd25, 1'b1, 4'h5));

    // ---- backpressure: 8 back-to-back, 5-cycle stall mid-stream ----
    sent = 0;
    for (int c = 0; c < 60 && (sent < 8 || sb.size() > 0); c++) begin
      in_valid = (sent < 8);
      if (sent < 8) drive_random(TAG_W'(sent));
      out_ready = !(c >= 3 && c < 8);
      tick(acc);
      if (acc) sent++;
    end
    in_valid = 1'b0;
    check("bp_all_sent", 64'(sent), 64'(8));
    check("bp_drained", 64'(sb.size()), 64'(0));

    // ---- random traffic with random backpressure ----
    tag_ctr = '0;
    for (int c = 0; c < 300; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      drive_random(tag_ctr);
      out_ready = ($urandom_range(0, 9) < 7);
      tick(acc);
      if (acc) tag_ctr = tag_ctr + 1'b1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && sb.size() > 0; c++) tick(acc);
    check("rand_drained", 64'(sb.size()), 64'(0));

    // ---- flush with three in flight ----
    prefill3();
    flush = 1'b1;
    drive_random(4'hF);
    in_valid = 1'b1;
    #1 check("flush_in_ready", 64'(in_ready), 64'(0));
    check("flush_out_valid_before_edge", 64'(out_valid), 64'(1));
    @(posedge clk);
    #1 check("flush_out_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1 check("flush_no_emit", 64'(out_valid), 64'(0));
    end
    @(negedge clk);
    directed("post_flush", 26'h1234567, 5'd13, 1'b1, 4'h9, model(26'h1234567, 5'd13, 1'b1, 4'h9));

    // ---- asynchronous reset with three in flight ----
    prefill3();
    #2 rst_n = 1'b0;
    #1 check("arst_out_valid", 64'(out_valid), 64'(0));
    check("arst_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1 check("arst_no_emit", 64'(out_valid), 64'(0));
    end
    @(negedge clk);
    directed("post_rst", 26'h3FF0001, 5'd30, 1'b0, 4'hA, model(26'h3FF0001, 5'd30, 1'b0, 4'hA));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
